morse_encoder: RTL

Transmit-side counterpart of the Morse letter decoder. Accepts a 5-bit letter code (A=1 … Z=26, the same encoding the decoder emits), looks up its dot/dash pattern and drives a timed on/off KEY line. Emits SHORT/LONG/END_CHAR-style symbol pulses so the output can be looped back into the decoder for self-test. Sits between the character source (keyboard/UART front end) and the keyer/LED/tone driver.

---
 rtl/morse_encoder_pkg.sv | 35 +++
 rtl/morse_rom.sv | 42 ++++
 rtl/morse_encoder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/morse_encoder_pkg.sv
// rtl/morse_encoder_pkg.sv - shared letter codes, timing units and lookup types for the Morse encoder
package morse_encoder_pkg;

    typedef enum logic [4:0] {
        LTR_INIT = 5'd0,
        LTR_A = 5'd1,  LTR_B = 5'd2,  LTR_C = 5'd3,  LTR_D = 5'd4,  LTR_E = 5'd5,
        LTR_F = 5'd6,  LTR_G = 5'd7,  LTR_H = 5'd8,  LTR_I = 5'd9,  LTR_J = 5'd10,
        LTR_K = 5'd11, LTR_L = 5'd12, LTR_M = 5'd13, LTR_N = 5'd14, LTR_O = 5'd15,
        LTR_P = 5'd16, LTR_Q = 5'd17, LTR_R = 5'd18, LTR_S = 5'd19, LTR_T = 5'd20,
        LTR_U = 5'd21, LTR_V = 5'd22, LTR_W = 5'd23, LTR_X = 5'd24, LTR_Y = 5'd25,
        LTR_Z = 5'd26,
        LTR_DONE = 5'd31
    } letter_e;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int MAX_LEN        = 4;

    // pattern is left-aligned: first element in bit 3, 1 = dash
    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [3:0] pattern;
    } morse_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_GAP
    } state_e;

endpackage

// File: rtl/morse_rom.sv
// rtl/morse_rom.sv - combinational letter code to dot/dash pattern lookup
module morse_rom
    import morse_encoder_pkg::*;
(
    input  logic [4:0]  letter,
    output morse_code_t code
);

    always_comb begin
        code = '0;
        case (letter_e'(letter))
            LTR_A: code = {1'b1, 3'd2, 4'b0100};
            LTR_B: code = {1'b1, 3'd4, 4'b1000};
            LTR_C: code = {1'b1, 3'd4, 4'b1010};
            LTR_D: code = {1'b1, 3'd3, 4'b1000};
            LTR_E: code = {1'b1, 3'd1, 4'b0000};
            LTR_F: code = {1'b1, 3'd4, 4'b0010};
            LTR_G: code = {1'b1, 3'd3, 4'b1100};
            LTR_H: code = {1'b1, 3'd4, 4'b0000};
            LTR_I: code = {1'b1, 3'd2, 4'b0000};
            LTR_J: code = {1'b1, 3'd4, 4'b0111};
            LTR_K: code = {1'b1, 3'd3, 4'b1010};
            LTR_L: code = {1'b1, 3'd4, 4'b0100};
            LTR_M: code = {1'b1, 3'd2, 4'b1100};
            LTR_N: code = {1'b1, 3'd2, 4'b1000};
            LTR_O: code = {1'b1, 3'd3, 4'b1110};
            LTR_P: code = {1'b1, 3'd4, 4'b0110};
            LTR_Q: code = {1'b1, 3'd4, 4'b1101};
            LTR_R: code = {1'b1, 3'd3, 4'b0100};
            LTR_S: code = {1'b1, 3'd3, 4'b0000};
            LTR_T: code = {1'b1, 3'd1, 4'b1000};
            LTR_U: code = {1'b1, 3'd3, 4'b0010};
            LTR_V: code = {1'b1, 3'd4, 4'b0001};
            LTR_W: code = {1'b1, 3'd3, 4'b0110};
            LTR_X: code = {1'b1, 3'd4, 4'b1001};
            LTR_Y: code = {1'b1, 3'd4, 4'b1011};
            LTR_Z: code = {1'b1, 3'd4, 4'b1100};
            default: code = '0;
        endcase
    end

endmodule

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - keys out one Morse letter with timed marks/gaps and loopback symbol pulses
module morse_encoder
    import morse_encoder_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic       Clk,
    input  logic       RESET,
    input  logic [4:0] LETTER,
    input  logic       START,
    output logic       READY,
    output logic       KEY,
    output logic       SYM_SHORT,
    output logic       SYM_LONG,
    output logic       SYM_END,
    output logic       DONE,
    output logic       ERR
);

    // counters hold cycles remaining minus one, so a phase ends when the count reaches zero
    localparam logic [CNT_W-1:0] DOT_LAST      = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LAST     = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ELEM_GAP_LAST = CNT_W'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHAR_GAP_LAST = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);

    morse_code_t rom_code;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pat_q, pat_d;
    logic [2:0]       rem_q, rem_d;
    logic             key_q, key_d;
    logic             ready_q, ready_d;
    logic             sym_short_q, sym_short_d;
    logic             sym_long_q, sym_long_d;
    logic             sym_end_q, sym_end_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    morse_rom u_rom (
        .letter (LETTER),
        .code   (rom_code)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pat_d       = pat_q;
        rem_d       = rem_q;
        key_d       = key_q;
        ready_d     = ready_q;
        sym_short_d = 1'b0;
        sym_long_d  = 1'b0;
        sym_end_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                key_d   = 1'b0;
                if (START) begin
                    if (rom_code.valid) begin
                        state_d = ST_MARK;
                        pat_d   = rom_code.pattern;
                        rem_d   = rom_code.len;
                        cnt_d   = rom_code.pattern[3] ? DASH_LAST : DOT_LAST;
                        key_d   = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (cnt_q == '0) begin
                    key_d       = 1'b0;
                    sym_long_d  = pat_q[3];
                    sym_short_d = ~pat_q[3];
                    pat_d       = {pat_q[2:0], 1'b0};
                    rem_d       = rem_q - 3'd1;
                    if (rem_q > 3'd1) begin
                        state_d = ST_SPACE;
                        cnt_d   = ELEM_GAP_LAST;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = CHAR_GAP_LAST;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SPACE: begin
                if (cnt_q == '0) begin
                    state_d = ST_MARK;
                    key_d   = 1'b1;
                    cnt_d   = pat_q[3] ? DASH_LAST : DOT_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    ready_d   = 1'b1;
                    sym_end_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pat_q       <= '0;
            rem_q       <= '0;
            key_q       <= 1'b0;
            ready_q     <= 1'b1;
            sym_short_q <= 1'b0;
            sym_long_q  <= 1'b0;
            sym_end_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            rem_q       <= rem_d;
            key_q       <= key_d;
            ready_q     <= ready_d;
            sym_short_q <= sym_short_d;
            sym_long_q  <= sym_long_d;
            sym_end_q   <= sym_end_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign READY     = ready_q;
    assign KEY       = key_q;
    assign SYM_SHORT = sym_short_q;
    assign SYM_LONG  = sym_long_q;
    assign SYM_END   = sym_end_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule
